// File: rtl/spi_master_multi.sv
// ----------------------------------------------------------------------------
// spi_master_multi : SPI master, N_SS selects, all four CPOL/CPHA modes.
// Macro SPI_LSB_FIRST_EN selects LSB-first bit order.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_master_multi #(
   parameter int WIDTH   = 8,
   parameter int N_SS    = 3,
   parameter int CLK_DIV = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [WIDTH-1:0]        tx_data,
   input  logic [$clog2(N_SS)-1:0] ss_sel,
   input  logic [1:0]              mode,
   output logic                    busy,
   output logic                    done,
   output logic [WIDTH-1:0]        rx_data,
   output logic                    sclk,
   output logic                    mosi,
   input  logic                    miso,
   output logic [N_SS-1:0]         ss_n
);

   localparam int SW = $clog2(N_SS);
   localparam int EW = $clog2(2*WIDTH+1);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [SW:0]   NSS_C    = (SW+1)'(N_SS);
   localparam logic [EW-1:0] LAST_EDG = EW'(2*WIDTH);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV-1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]       state;
   logic [DW-1:0]    div_cnt;
   logic [EW-1:0]    edge_cnt;
   logic [WIDTH-1:0] tx_shift;
   logic [WIDTH-1:0] rx_shift;
   logic             cpol_q;
   logic             cpha_q;

   logic             sel_ok;
   logic             div_wrap;
   logic [EW-1:0]    edge_num;
   logic             sample_edge;
   logic             tx_first;
   logic [WIDTH-1:0] tx_load;
   logic             tx_out;
   logic [WIDTH-1:0] tx_next;
   logic [WIDTH-1:0] rx_next;

   assign sel_ok      = ({1'b0, ss_sel} < NSS_C);
   assign div_wrap    = (div_cnt == DIV_LAST);
   assign edge_num    = edge_cnt + EW'(1);
   // Odd edges sample in CPHA=0, even edges sample in CPHA=1; the rest shift.
   assign sample_edge = edge_num[0] ^ cpha_q;

`ifdef SPI_LSB_FIRST_EN
   assign tx_first = tx_data[0];
   assign tx_load  = tx_data >> 1;
   assign tx_out   = tx_shift[0];
   assign tx_next  = tx_shift >> 1;
   assign rx_next  = {miso, rx_shift[WIDTH-1:1]};
`else
   assign tx_first = tx_data[WIDTH-1];
   assign tx_load  = tx_data << 1;
   assign tx_out   = tx_shift[WIDTH-1];
   assign tx_next  = tx_shift << 1;
   assign rx_next  = {rx_shift[WIDTH-2:0], miso};
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_data  <= '0;
         mosi     <= 1'b0;
         ss_n     <= '1;
         sclk     <= 1'b0;
         div_cnt  <= '0;
         edge_cnt <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && sel_ok) begin
                  state    <= S_SETUP;
                  busy     <= 1'b1;
                  cpol_q   <= mode[1];
                  cpha_q   <= mode[0];
                  sclk     <= mode[1];
                  div_cnt  <= '0;
                  edge_cnt <= '0;
                  rx_shift <= '0;
                  for (int i = 0; i < N_SS; i++) begin
                     ss_n[i] <= (ss_sel != SW'(i));
                  end
                  // CPHA=0 presents the first bit before the first edge.
                  if (mode[0]) begin
                     mosi     <= 1'b0;
                     tx_shift <= tx_data;
                  end else begin
                     mosi     <= tx_first;
                     tx_shift <= tx_load;
                  end
               end
            end
            S_SETUP, S_XFER: begin
               if (div_wrap) begin
                  div_cnt  <= '0;
                  sclk     <= ~sclk;
                  edge_cnt <= edge_num;
                  if (sample_edge) begin
                     rx_shift <= rx_next;
                  end else begin
                     mosi     <= tx_out;
                     tx_shift <= tx_next;
                  end
                  state <= (edge_num == LAST_EDG) ? S_HOLD : S_XFER;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            S_HOLD: begin
               if (div_wrap) begin
                  state   <= S_IDLE;
                  div_cnt <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  ss_n    <= '1;
                  rx_data <= rx_shift;
                  mosi    <= 1'b0;
                  sclk    <= cpol_q;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
